vreg_file_lanes: RTL and testbench

Parametrised vector register file for the SIMD datapath: DEPTH entries of LANES×LANE_W bits, two registered read ports, one write port with a per-lane write mask and same-cycle write-to-read bypass. After reset it runs an internal clear sequence that zeroes every entry and holds `busy` high until the array is clean. Entry 0 always reads as zero. The block sits between the decode stage (read addresses) and the writeback stage (write port), and replaces the fixed 256-bit file.

---
 rtl/vreg_file_lanes.sv | 87 ++++++++
 tb/tb_vreg_file_lanes.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vreg_file_lanes.sv
// Vector register file: two registered read ports with write bypass, one lane-masked write port, entry 0 hardwired to zero.
// Read latency is 1 cycle. There is no backpressure in RUN; busy covers reset and the post-reset clear sweep.
module vreg_file_lanes #(
  parameter int LANES  = 8,
  parameter int LANE_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [LANES-1:0]        wmask,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic [AW-1:0]           ra1,
  input  logic [AW-1:0]           ra2,
  output logic [LANES*LANE_W-1:0] rd1,
  output logic [LANES*LANE_W-1:0] rd2,
  output logic                    busy
);

  localparam int W = LANES * LANE_W;
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t         state;
  logic [AW:0]    cnt;
  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   merged1;
  logic [W-1:0]   merged2;

  // Same-cycle writes are folded into the read result lane by lane.
  always_comb begin
    merged1 = mem[ra1];
    merged2 = mem[ra2];
    for (int i = 0; i < LANES; i++) begin
      if (we && wmask[i] && (waddr == ra1))
        merged1[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
      if (we && wmask[i] && (waddr == ra2))
        merged2[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
      rd1   <= '0;
      rd2   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + CNT_ONE;
          rd1 <= '0;
          rd2 <= '0;
          if (cnt == CNT_LAST) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          rd1 <= (ra1 == '0) ? '0 : merged1;
          rd2 <= (ra2 == '0) ? '0 : merged2;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // The array has no reset of its own; the clear sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt[AW-1:0]] <= '0;
      end else if (we && (waddr != '0)) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i])
            mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_vreg_file_lanes.sv
// Scoreboard bench for vreg_file_lanes: expected read data queued when driven, compared after the capturing edge.
module tb_vreg_file_lanes;
  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int W      = LANES * LANE_W;

  logic          clk;
  logic          rst;
  logic          we;
  logic [LANES-1:0] wmask;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [W-1:0]  rd1;
  logic [W-1:0]  rd2;
  logic          busy;

  logic [W-1:0]  model [DEPTH];
  logic [W-1:0]  exp_q [$];
  int            checks;
  int            fails;

  vreg_file_lanes #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] expect_read(input logic w, input logic [LANES-1:0] m,
      input logic [AW-1:0] wa, input logic [W-1:0] wd, input logic [AW-1:0] a);
    logic [W-1:0] e;
    e = model[a];
    for (int i = 0; i < LANES; i++)
      if (w && m[i] && wa == a) e[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    if (a == '0) e = '0;
    return e;
  endfunction

  // Drives one RUN cycle, queues both expected read results, then advances the model.
  task automatic apply(input logic w, input logic [LANES-1:0] m, input logic [AW-1:0] wa,
      input logic [W-1:0] wd, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    we = w; wmask = m; waddr = wa; wdata = wd; ra1 = a1; ra2 = a2;
    exp_q.push_back(expect_read(w, m, wa, wd, a1));
    exp_q.push_back(expect_read(w, m, wa, wd, a2));
    @(posedge clk); #1;
    if (w && wa != '0)
      for (int i = 0; i < LANES; i++)
        if (m[i]) model[wa][i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    we = 1'b0;
  endtask

  task automatic clear_model();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
  endtask

  task automatic test_reset();
    int n;
    logic [W-1:0] e1, e2;
    rst = 1'b1; we = 1'b0; wmask = '0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (rd1 !== '0) begin fails++; $display("FAIL reset_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== '0) begin fails++; $display("FAIL reset_rd2 got=%h exp=0", rd2); end
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (busy && n < 100);
    checks++; if (n != DEPTH) begin fails++; $display("FAIL reset_clear_len got=%0d exp=%0d", n, DEPTH); end
    clear_model();
    for (int a = 1; a < DEPTH; a++) begin
      apply(1'b0, '0, '0, '0, AW'(a), AW'(DEPTH - a));
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++; if (rd1 !== e1) begin fails++; $display("FAIL reset_zero_rd1 a=%0d got=%h exp=%h", a, rd1, e1); end
      checks++; if (rd2 !== e2) begin fails++; $display("FAIL reset_zero_rd2 a=%0d got=%h exp=%h", a, rd2, e2); end
    end
  endtask

  task automatic test_full_write();
    logic [W-1:0] d, e1, e2;
    for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = 32'h11111111 * (i + 1);
    apply(1'b1, 8'hFF, 5'd5, d, 5'd0, 5'd0);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== e1) begin fails++; $display("FAIL full_wr_rd1 got=%h exp=%h", rd1, e1); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL full_wr_rd2 got=%h exp=%h", rd2, e2); end
    apply(1'b0, '0, '0, '0, 5'd5, 5'd5);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== d) begin fails++; $display("FAIL full_rd1 got=%h exp=%h", rd1, d); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL full_rd2 got=%h exp=%h", rd2, e2); end
  endtask

  task automatic test_masked_write();
    logic [W-1:0] e1, e2, want;
    want = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
            {4{32'hDEADBEEF}}};
    apply(1'b1, 8'h0F, 5'd5, {LANES{32'hDEADBEEF}}, 5'd1, 5'd2);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    apply(1'b0, '0, '0, '0, 5'd5, 5'd5);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== want) begin fails++; $display("FAIL masked_rd1 got=%h exp=%h", rd1, want); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL masked_rd2 got=%h exp=%h", rd2, e2); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] e1, e2, want;
    want = {{4{32'hA5A5A5A5}}, {4{32'h0}}};
    apply(1'b1, 8'hF0, 5'd9, {LANES{32'hA5A5A5A5}}, 5'd9, 5'd9);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== want) begin fails++; $display("FAIL bypass_rd1 got=%h exp=%h", rd1, want); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL bypass_rd2 got=%h exp=%h", rd2, e2); end
    apply(1'b0, '0, '0, '0, 5'd9, 5'd5);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== e1) begin fails++; $display("FAIL bypass_array_rd1 got=%h exp=%h", rd1, e1); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL bypass_array_rd2 got=%h exp=%h", rd2, e2); end
  endtask

  task automatic test_entry0();
    logic [W-1:0] e1, e2;
    apply(1'b1, 8'hFF, 5'd0, {W{1'b1}}, 5'd0, 5'd0);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== '0) begin fails++; $display("FAIL entry0_same_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL entry0_same_rd2 got=%h exp=%h", rd2, e2); end
    apply(1'b0, '0, '0, '0, 5'd0, 5'd0);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== '0) begin fails++; $display("FAIL entry0_next_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL entry0_next_rd2 got=%h exp=%h", rd2, e2); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [W-1:0] e1, e2;
    apply(1'b1, 8'hFF, 5'd7, {LANES{32'h0BADF00D}}, 5'd0, 5'd0);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    rst = 1'b1; ra1 = 5'd7; ra2 = 5'd7;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_rst_busy got=%b exp=1", busy); end
    checks++; if (rd1 !== '0) begin fails++; $display("FAIL mid_rst_rd1 got=%h exp=0", rd1); end
    rst = 1'b0;
    n = 0;
    do begin
      we = 1'b1; wmask = 8'hFF; waddr = 5'd7; wdata = {8{$urandom}};
      @(posedge clk); #1; n++;
      checks++; if (rd1 !== '0) begin fails++; $display("FAIL mid_clear_rd1 n=%0d got=%h exp=0", n, rd1); end
    end while (busy && n < 100);
    we = 1'b0;
    checks++; if (n != DEPTH) begin fails++; $display("FAIL mid_clear_len got=%0d exp=%0d", n, DEPTH); end
    clear_model();
    apply(1'b0, '0, '0, '0, 5'd7, 5'd7);
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++; if (rd1 !== '0) begin fails++; $display("FAIL mid_addr7_rd1 got=%h exp=0", rd1); end
    checks++; if (rd2 !== e2) begin fails++; $display("FAIL mid_addr7_rd2 got=%h exp=%h", rd2, e2); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d, e1, e2;
    logic [AW-1:0] wa, a1, a2;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = $urandom;
      wa = AW'($urandom_range(0, DEPTH - 1));
      a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      a2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      apply(1'($urandom_range(0, 1)), LANES'($urandom), wa, d, a1, a2);
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++; if (rd1 !== e1) begin fails++; $display("FAIL b2b_rd1 c=%0d got=%h exp=%h", c, rd1, e1); end
      checks++; if (rd2 !== e2) begin fails++; $display("FAIL b2b_rd2 c=%0d got=%h exp=%h", c, rd2, e2); end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_full_write();
    test_masked_write();
    test_bypass();
    test_entry0();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
